// File: rtl/eth_tx_arb.sv
// eth_tx_arb: multi-channel GMII transmit arbiter.
//   Grants one requesting channel at a time (fixed priority or round robin),
//   forwards the granted channel's GMII byte stream with one cycle of
//   register latency, then forces IFG_CYC idle cycles before the next grant.
//   A granted channel that does not raise tx_en within GRANT_TO cycles
//   loses its grant.
// Parameters: CH_NUM (2..8), ARB_MODE (0 fixed, 1 round robin),
//             IFG_CYC (1..255), GRANT_TO (2..1023).
// Ports:
//   clk, rst_n            GMII tx clock, async active-low reset
//   ch_req/ch_tx_en/ch_txd  per-channel request, data valid, byte (ch i at [8i+7:8i])
//   ch_grant/ch_done      one-hot grant, one-cycle frame-end pulse
//   gmii_tx_en/gmii_txd   merged GMII stream
//   busy                  high whenever the arbiter is not idle
//   frame_cnt             per-channel 16-bit frame counters, present only
//                         when macro ETH_TX_ARB_STAT_EN is defined
module eth_tx_arb #(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned IFG_CYC  = 12,
  parameter int unsigned GRANT_TO = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_NUM-1:0]    ch_req,
  input  logic [CH_NUM-1:0]    ch_tx_en,
  input  logic [8*CH_NUM-1:0]  ch_txd,
  output logic [CH_NUM-1:0]    ch_grant,
  output logic [CH_NUM-1:0]    ch_done,
  output logic                 gmii_tx_en,
  output logic [7:0]           gmii_txd,
  output logic                 busy
`ifdef ETH_TX_ARB_STAT_EN
  ,
  output logic [16*CH_NUM-1:0] frame_cnt
`endif
);

  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned CNT_W = 10;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);
  localparam logic [IDX_W:0]   CH_NUM_X = (IDX_W+1)'(CH_NUM);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(GRANT_TO - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XMIT  = 2'd2,
    S_IFG   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CH_NUM-1:0] grant_q, grant_d;
  logic [CH_NUM-1:0] done_q, done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gtx_q, gtx_d;
  logic [7:0]        gtxd_q, gtxd_d;
  logic              busy_q, busy_d;

  logic              sel_req;
  logic              sel_en;
  logic [7:0]        sel_txd;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  fp_idx;
  logic [IDX_W-1:0]  rot_off;
  logic [IDX_W:0]    rr_sum;
  logic [IDX_W-1:0]  rr_idx;
  logic [2*CH_NUM-1:0] req_dbl;
  logic [CH_NUM-1:0] req_rot;
  logic [IDX_W-1:0]  rr_next;

  // Signals of the currently granted channel; all other channels are never looked at.
  always_comb begin
    sel_req = 1'b0;
    sel_en  = 1'b0;
    sel_txd = 8'h00;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_req = ch_req[i];
        sel_en  = ch_tx_en[i];
        sel_txd = ch_txd[8*i +: 8];
      end
    end
  end

  // Winner selection: lowest index, or lowest index at/after rr_q with wrap.
  always_comb begin
    req_dbl = {ch_req, ch_req} >> rr_q;
    req_rot = req_dbl[CH_NUM-1:0];
    fp_idx  = '0;
    rot_off = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (ch_req[i])  fp_idx  = IDX_W'(i);
      if (req_rot[i]) rot_off = IDX_W'(i);
    end
    rr_sum  = {1'b0, rr_q} + {1'b0, rot_off};
    rr_idx  = (rr_sum >= CH_NUM_X) ? IDX_W'(rr_sum - CH_NUM_X) : IDX_W'(rr_sum);
    win_idx = (ARB_MODE == 0) ? fp_idx : rr_idx;
  end

  assign rr_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (|ch_req) state_d = S_GRANT;
      S_GRANT: begin
        if (sel_en)                 state_d = S_XMIT;
        else if (!sel_req)          state_d = S_IDLE;
        else if (cnt_q == TO_LAST)  state_d = S_IDLE;
      end
      S_XMIT:  if (!sel_en) state_d = S_IFG;
      S_IFG:   if (cnt_q == IFG_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. The counter is shared between grant
  // timeout and IFG; it never runs during XMIT so frame length is unbounded.
  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    gtx_d   = 1'b0;
    gtxd_d  = 8'h00;
    busy_d  = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|ch_req) begin
          idx_d   = win_idx;
          grant_d = CH_NUM'(1) << win_idx;
        end
      end
      S_GRANT: begin
        if (sel_en) begin
          gtx_d  = 1'b1;
          gtxd_d = sel_txd;
          cnt_d  = '0;
        end else if (!sel_req) begin
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          grant_d = '0;
          rr_d    = rr_next;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_XMIT: begin
        if (sel_en) begin
          gtx_d  = 1'b1;
          gtxd_d = sel_txd;
        end else begin
          done_d  = grant_q;
          grant_d = '0;
          rr_d    = rr_next;
          cnt_d   = '0;
        end
      end
      S_IFG: begin
        cnt_d = (cnt_q == IFG_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      done_q  <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gtx_q   <= 1'b0;
      gtxd_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gtx_q   <= gtx_d;
      gtxd_q  <= gtxd_d;
      busy_q  <= busy_d;
    end
  end

  assign ch_grant   = grant_q;
  assign ch_done    = done_q;
  assign gmii_tx_en = gtx_q;
  assign gmii_txd   = gtxd_q;
  assign busy       = busy_q;

`ifdef ETH_TX_ARB_STAT_EN
  // Per-channel frame counters, updated together with the ch_done pulse.
  logic [16*CH_NUM-1:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (done_d[i]) frame_cnt_q[16*i +: 16] <= frame_cnt_q[16*i +: 16] + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: instance A (2 ch, fixed priority, IFG 12, timeout 64)
// and instance B (4 ch, round robin, IFG 3, timeout 8), each compared every
// cycle against a transaction-level owner/gap model, plus directed checks.
module tb_eth_tx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // stimulus, indexed [instance][channel]
  logic [3:0] s_req [2];
  logic [3:0] s_en  [2];
  logic [7:0] s_txd [2][4];

  logic [1:0] a_grant, a_done;
  logic       a_gtx, a_busy;
  logic [7:0] a_gtxd;
  logic [3:0] b_grant, b_done;
  logic       b_gtx, b_busy;
  logic [7:0] b_gtxd;
`ifdef ETH_TX_ARB_STAT_EN
  logic [31:0] a_fc;
  logic [63:0] b_fc;
`endif

  eth_tx_arb #(.CH_NUM(2), .ARB_MODE(0), .IFG_CYC(12), .GRANT_TO(64)) u_a (
    .clk(clk), .rst_n(rst_n),
    .ch_req(s_req[0][1:0]), .ch_tx_en(s_en[0][1:0]),
    .ch_txd({s_txd[0][1], s_txd[0][0]}),
    .ch_grant(a_grant), .ch_done(a_done),
    .gmii_tx_en(a_gtx), .gmii_txd(a_gtxd), .busy(a_busy)
`ifdef ETH_TX_ARB_STAT_EN
    , .frame_cnt(a_fc)
`endif
  );

  eth_tx_arb #(.CH_NUM(4), .ARB_MODE(1), .IFG_CYC(3), .GRANT_TO(8)) u_b (
    .clk(clk), .rst_n(rst_n),
    .ch_req(s_req[1]), .ch_tx_en(s_en[1]),
    .ch_txd({s_txd[1][3], s_txd[1][2], s_txd[1][1], s_txd[1][0]}),
    .ch_grant(b_grant), .ch_done(b_done),
    .gmii_tx_en(b_gtx), .gmii_txd(b_gtxd), .busy(b_busy)
`ifdef ETH_TX_ARB_STAT_EN
    , .frame_cnt(b_fc)
`endif
  );

  logic [3:0] o_grant [2];
  logic [3:0] o_done  [2];
  logic       o_gtx   [2];
  logic [7:0] o_gtxd  [2];
  logic       o_busy  [2];
  assign o_grant[0] = {2'b00, a_grant};
  assign o_grant[1] = b_grant;
  assign o_done[0]  = {2'b00, a_done};
  assign o_done[1]  = b_done;
  assign o_gtx[0]   = a_gtx;
  assign o_gtx[1]   = b_gtx;
  assign o_gtxd[0]  = a_gtxd;
  assign o_gtxd[1]  = b_gtxd;
  assign o_busy[0]  = a_busy;
  assign o_busy[1]  = b_busy;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, k, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int nch  [2] = '{2, 4};
  int mode [2] = '{0, 1};
  int ifg  [2] = '{12, 3};
  int gto  [2] = '{64, 8};

  int  owner [2];   // granted channel, -1 when none
  bit  started [2]; // granted channel has begun its frame
  int  waitc [2];   // cycles spent granted without tx_en
  int  gap   [2];   // remaining inter-frame gap cycles
  int  rr    [2];
  int  fcnt  [2][4];
  logic [3:0] e_done [2];
  bit         e_gtx  [2];
  logic [7:0] e_gtxd [2];

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; started[k] = 0; waitc[k] = 0; gap[k] = 0; rr[k] = 0;
      e_done[k] = '0; e_gtx[k] = 0; e_gtxd[k] = 8'h00;
      for (int c = 0; c < 4; c++) fcnt[k][c] = 0;
    end
  endtask

  function automatic int pick(input int k, input logic [3:0] rq);
    int j;
    for (int off = 0; off < nch[k]; off++) begin
      j = (mode[k] == 0) ? off : (rr[k] + off) % nch[k];
      if (rq[j]) return j;
    end
    return -1;
  endfunction

  task automatic mdl_step(input int k);
    int o;
    e_done[k] = '0; e_gtx[k] = 0; e_gtxd[k] = 8'h00;
    o = owner[k];
    if (gap[k] > 0) begin
      gap[k]--;
    end else if (o < 0) begin
      if (s_req[k] != 4'b0000) begin
        owner[k] = pick(k, s_req[k]); started[k] = 0; waitc[k] = 0;
      end
    end else if (!started[k]) begin
      if (s_en[k][o]) begin
        started[k] = 1; e_gtx[k] = 1; e_gtxd[k] = s_txd[k][o];
      end else if (!s_req[k][o]) begin
        owner[k] = -1;
      end else if (waitc[k] == gto[k] - 1) begin
        rr[k] = (o + 1) % nch[k]; owner[k] = -1;
      end else begin
        waitc[k]++;
      end
    end else begin
      if (s_en[k][o]) begin
        e_gtx[k] = 1; e_gtxd[k] = s_txd[k][o];
      end else begin
        e_done[k][o] = 1'b1; fcnt[k][o]++;
        rr[k] = (o + 1) % nch[k]; owner[k] = -1; gap[k] = ifg[k];
      end
    end
  endtask

  // compare process: every cycle, 1 time unit after the rising edge
  initial begin
    logic [3:0] eg;
    mdl_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) mdl_reset();
      else for (int k = 0; k < 2; k++) mdl_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        eg = (owner[k] >= 0) ? (4'b0001 << owner[k]) : 4'b0000;
        chk("grant",    k, 32'(o_grant[k]), 32'(eg));
        chk("done",     k, 32'(o_done[k]),  32'(e_done[k]));
        chk("gmii_en",  k, 32'(o_gtx[k]),   32'(e_gtx[k]));
        chk("gmii_txd", k, 32'(o_gtxd[k]),  32'(e_gtxd[k]));
        chk("busy",     k, 32'(o_busy[k]),  32'(owner[k] >= 0 || gap[k] > 0));
      end
`ifdef ETH_TX_ARB_STAT_EN
      for (int c = 0; c < 2; c++) chk("frame_cnt", 0, 32'(a_fc[16*c +: 16]), 32'(fcnt[0][c] & 16'hFFFF));
      for (int c = 0; c < 4; c++) chk("frame_cnt", 1, 32'(b_fc[16*c +: 16]), 32'(fcnt[1][c] & 16'hFFFF));
`endif
    end
  end

  // ---------------- random source engine ----------------
  int st  [2][4];
  int dly [2][4];
  int len [2][4];

  task automatic rand_step();
    bit g;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < nch[k]; c++) begin
        g = o_grant[k][c];
        if (st[k][c] == 0) begin
          s_req[k][c] = 1'b0;
          if ($urandom % 6 == 0) begin st[k][c] = 1; s_req[k][c] = 1'b1; end
        end else if (st[k][c] == 1 && g) begin
          st[k][c] = 2;
          if ($urandom % 5 == 0) dly[k][c] = 300;
          else dly[k][c] = int'($urandom % 4);
        end
        if (st[k][c] == 2) begin
          if (!g || ($urandom % 40 == 0)) begin
            st[k][c] = 0; s_req[k][c] = 1'b0;
          end else if (dly[k][c] == 0) begin
            st[k][c] = 3; len[k][c] = 1 + int'($urandom % 12);
          end else begin
            dly[k][c]--;
          end
        end
        if (st[k][c] == 3) begin
          if (len[k][c] > 0) begin
            s_en[k][c] = 1'b1; s_txd[k][c] = 8'($urandom); len[k][c]--;
          end else begin
            s_en[k][c] = 1'b0; st[k][c] = 4;
          end
        end
        if (st[k][c] == 4 && !g) begin
          st[k][c] = 0; s_req[k][c] = 1'b0;
        end
        if (!g) begin
          s_en[k][c] = 1'($urandom); s_txd[k][c] = 8'($urandom);
        end else if (st[k][c] != 3) begin
          s_en[k][c] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w, idx, extra;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_req[k] = '0; s_en[k] = '0;
      for (int c = 0; c < 4; c++) begin
        s_txd[k][c] = 8'h00; st[k][c] = 0; dly[k][c] = 0; len[k][c] = 0;
      end
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 0, 32'(a_grant), 32'h0);
    chk("rst_busy",  0, 32'(a_busy),  32'h0);
    chk("rst_gmii",  0, {23'd0, a_gtx, a_gtxd}, 32'h0);
    chk("rst_grant", 1, 32'(b_grant), 32'h0);
    rst_n = 1'b1;

    // round robin, all four requesting, 8 frames of 2 bytes
    @(negedge clk);
    s_req[1] = 4'hF;
    for (int f = 0; f < 8; f++) begin
      w = 0;
      while (b_grant == 4'h0 && w < 100) begin @(negedge clk); w++; end
      chk("rr_wait", 1, 32'(w < 100), 32'h1);
      idx = -1;
      for (int c = 0; c < 4; c++) if (b_grant[c]) idx = c;
      chk("rr_order", 1, 32'(idx), 32'(f % 4));
      if (idx < 0) idx = 0;
      s_en[1][idx] = 1'b1; s_txd[1][idx] = 8'($urandom);
      @(negedge clk);
      s_txd[1][idx] = 8'($urandom);
      @(negedge clk);
      s_en[1][idx] = 1'b0;
      @(negedge clk);
    end
    s_req[1] = 4'h0;
    repeat (10) @(negedge clk);

    // fixed priority with simultaneous requests, 64-byte frame on ch0
    s_req[0] = 2'b11; s_en[0][1] = 1'b1; s_txd[0][1] = 8'hAA;
    @(negedge clk);
    chk("prio_grant", 0, 32'(a_grant), 32'h1);
    for (int i = 0; i < 64; i++) begin
      if (i > 0) chk("payload", 0, {23'd0, a_gtx, a_gtxd}, {23'd0, 1'b1, 8'(i - 1)});
      s_en[0][0] = 1'b1; s_txd[0][0] = 8'(i);
      @(negedge clk);
    end
    chk("payload", 0, {23'd0, a_gtx, a_gtxd}, {23'd0, 1'b1, 8'h3F});
    s_en[0][0] = 1'b0;
    @(negedge clk);
    chk("done_pulse", 0, 32'(a_done), 32'h1);
    chk("grant_clr",  0, 32'(a_grant), 32'h0);
    chk("gmii_fall",  0, 32'(a_gtx), 32'h0);
    s_req[0][0] = 1'b0; s_en[0][1] = 1'b0;
    w = 0; extra = 0;
    while (a_grant != 2'b10 && w < 50) begin
      @(negedge clk); w++;
      if (a_done != 2'b00) extra++;
    end
    chk("ifg_wait",  0, 32'(w), 32'd13);
    chk("done_once", 0, 32'(extra), 32'd0);

    // ch1 never starts: grant lasts GRANT_TO cycles, then ch0 is served
    s_req[0][0] = 1'b1;
    w = 0; extra = 0;
    while (a_grant == 2'b10 && w < 200) begin
      if (a_done != 2'b00) extra++;
      w++;
      @(negedge clk);
    end
    chk("timeout_len",  0, 32'(w), 32'd64);
    chk("timeout_done", 0, 32'(extra), 32'd0);
    chk("timeout_idle", 0, 32'(a_grant), 32'h0);
    @(negedge clk);
    chk("next_grant", 0, 32'(a_grant), 32'h1);

    // reset at byte 20 of a ch0 frame
    for (int i = 0; i < 20; i++) begin
      s_en[0][0] = 1'b1; s_txd[0][0] = 8'(8'h80 + i);
      @(negedge clk);
    end
    chk("mid_frame", 0, {23'd0, a_gtx, a_gtxd}, {23'd0, 1'b1, 8'h93});
    rst_n = 1'b0;
    #1;
    chk("rst_gmii_now",  0, 32'(a_gtx),   32'h0);
    chk("rst_done_now",  0, 32'(a_done),  32'h0);
    chk("rst_grant_now", 0, 32'(a_grant), 32'h0);
    chk("rst_busy_now",  0, 32'(a_busy),  32'h0);
    s_en[0] = '0; s_req[0] = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 0, 32'(a_grant), 32'h2);
    s_en[0][1] = 1'b1;
    repeat (3) begin s_txd[0][1] = 8'($urandom); @(negedge clk); end
    s_en[0][1] = 1'b0;
    @(negedge clk);
    s_req[0] = '0;
    repeat (20) @(negedge clk);

    // randomized traffic on both instances
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      rand_step();
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin s_req[k] = '0; s_en[k] = '0; end
    repeat (40) @(negedge clk);
    chk("final_idle", 0, 32'(a_busy), 32'h0);
    chk("final_idle", 1, 32'(b_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
